// File: rtl/fpmul_share_ctrl.sv
// fpmul_share_ctrl: shares one non-stallable FP32 multiplier between two requesters,
// with credit backpressure and per-port response FIFOs. Macro FPMUL_SHARE_FIXED_PRIO_EN selects fixed priority.
`default_nettype none

module fpmul_share_ctrl #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [31:0] req_a0_i,
  input  logic [31:0] req_b0_i,
  input  logic [31:0] req_a1_i,
  input  logic [31:0] req_b1_i,
  output logic        mul_issue_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic        mul_res_valid_i,
  input  logic [31:0] mul_res_i,
  input  logic [3:0]  mul_flags_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [35:0] rsp_data0_o,
  output logic [35:0] rsp_data1_o,
  output logic        seq_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(LAT + 2);

  logic [1:0]  elig_w;
  logic [1:0]  grant_w;
  logic [1:0]  accept_w;
  logic [1:0]  pop_w;
  logic [1:0]  push_w;
  logic [35:0] head_w [2];

  // ---------------------------------------------------------------- arbitration
`ifdef FPMUL_SHARE_FIXED_PRIO_EN
  always_comb begin
    grant_w = 2'b00;
    if (elig_w[0]) begin
      grant_w = 2'b01;
    end else if (elig_w[1]) begin
      grant_w = 2'b10;
    end
  end
`else
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_w = elig_w;
    if (elig_w == 2'b11) begin
      grant_w = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_w != 2'b00) begin
      last_grant_d = accept_w[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign req_ready_o = rst_ni ? grant_w : 2'b00;
  assign accept_w    = req_valid_i & req_ready_o;

  // ---------------------------------------------------------------- issue stage
  logic        issue_q;
  logic        issue_port_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issue_q      <= 1'b0;
      issue_port_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
    end else begin
      issue_q      <= |accept_w;
      issue_port_q <= accept_w[1];
      if (|accept_w) begin
        mul_a_q <= accept_w[1] ? req_a1_i : req_a0_i;
        mul_b_q <= accept_w[1] ? req_b1_i : req_b0_i;
      end
    end
  end

  assign mul_issue_o = issue_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

  // ---------------------------------------------------------------- tag pipeline
  // Loaded from the issue register so the tail lines up with mul_res_valid_i.
  logic [LAT-1:0] tag_v_q;
  logic [LAT-1:0] tag_p_q;
  logic           tail_v_w;
  logic           tail_p_w;

  if (LAT == 1) begin : g_tag_single
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        tag_v_q <= '0;
        tag_p_q <= '0;
      end else begin
        tag_v_q <= issue_q;
        tag_p_q <= issue_port_q;
      end
    end
  end else begin : g_tag_shift
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        tag_v_q <= '0;
        tag_p_q <= '0;
      end else begin
        tag_v_q <= {tag_v_q[LAT-2:0], issue_q};
        tag_p_q <= {tag_p_q[LAT-2:0], issue_port_q};
      end
    end
  end

  assign tail_v_w  = tag_v_q[LAT-1];
  assign tail_p_w  = tag_p_q[LAT-1];
  assign push_w[0] = tail_v_w & mul_res_valid_i & ~tail_p_w;
  assign push_w[1] = tail_v_w & mul_res_valid_i &  tail_p_w;

  // ---------------------------------------------------------------- sequence check
  logic [DW-1:0] drain_q;
  logic          seq_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drain_q   <= DW'(LAT + 1);
      seq_err_q <= 1'b0;
    end else begin
      if (drain_q != '0) begin
        drain_q <= drain_q - DW'(1);
      end else if (tail_v_w != mul_res_valid_i) begin
        seq_err_q <= 1'b1;
      end
    end
  end

  assign seq_err_o = seq_err_q;

  // ---------------------------------------------------------------- per-port credits and FIFOs
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;

    assign elig_w[p]      = req_valid_i[p] && (credit_q != '0);
    assign rsp_valid_o[p] = (cnt_q != '0);
    assign pop_w[p]       = rsp_valid_o[p] & rsp_ready_i[p];
    assign head_w[p]      = rsp_valid_o[p] ? mem_q[rptr_q] : '0;

    // A pop returns its credit only from the following cycle on.
    always_comb begin
      credit_d = credit_q - CW'(accept_w[p]) + CW'(pop_w[p]);
    end

    always_ff @(posedge clk_i) begin
      if (push_w[p]) begin
        mem_q[wptr_q] <= {mul_flags_i, mul_res_i};
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        cnt_q    <= '0;
        credit_q <= CW'(DEPTH);
      end else begin
        credit_q <= credit_d;
        cnt_q    <= cnt_q + CW'(push_w[p]) - CW'(pop_w[p]);
        if (push_w[p]) begin
          wptr_q <= wptr_q + AW'(1);
        end
        if (pop_w[p]) begin
          rptr_q <= rptr_q + AW'(1);
        end
      end
    end
  end

  assign rsp_data0_o = head_w[0];
  assign rsp_data1_o = head_w[1];

endmodule

`default_nettype wire
